// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD host driver: default data width and the
// sequencer state encoding.
package gcd_pkg;

  localparam int GCD_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

endpackage

// File: rtl/gcd_host_driver.sv
// Initiator-side sequencer for the subtraction GCD core.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for an operand pair; zero operands answered locally
// S_LOAD_A | start pulse, operand A on the shared bus
// S_LOAD_B | operand B on the shared bus, timeout counter cleared
// S_WAIT   | waiting for core done, bounded by TIMEOUT cycles
// S_RESP   | result held on the output channel until accepted
//
// Every output is a register loaded from the next-state view, so nothing
// combinational reaches an output port.
module gcd_host_driver
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         busy,
  output logic         gcd_start,
  output logic [W-1:0] gcd_data,
  input  logic         gcd_done,
  input  logic [W-1:0] gcd_result
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  ra_q, ra_d;
  logic [W-1:0]  rb_q, rb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_gcd_q, out_gcd_d;
  logic          out_err_q, out_err_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic [W-1:0]  data_q, data_d;

  // Sequencing: next state, operand capture, timeout count and result capture.
  // gcd_done is only looked at in S_WAIT so a level left high by the previous
  // run cannot be mistaken for completion of the current one.
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    cnt_d     = cnt_q;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          ra_d = in_a;
          rb_d = in_b;
          // The core would subtract forever on a zero operand.
          if ((in_a == '0) || (in_b == '0)) begin
            state_d   = S_RESP;
            out_gcd_d = in_a | in_b;
            out_err_d = (in_a == '0) && (in_b == '0);
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (gcd_done) begin
          state_d   = S_RESP;
          out_gcd_d = gcd_result;
          out_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          out_gcd_d = '0;
          out_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register inputs, decoded from the state being entered.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_LOAD_A);
    out_valid_d = (state_d == S_RESP);
    case (state_d)
      S_LOAD_A:         data_d = ra_d;
      S_LOAD_B, S_WAIT: data_d = rb_d;
      default:          data_d = '0;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      cnt_q       <= '0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      cnt_q       <= cnt_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      data_q      <= data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = out_gcd_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;
  assign gcd_start = start_q;
  assign gcd_data  = data_q;

endmodule
